// File: rtl/vedic_pkg.sv
// Shared width helpers for the pipelined Vedic multiplier and its recursive core.
package vedic_pkg;

    function automatic int half_w(input int w);
        return w / 2;
    endfunction

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/vedic_nxn_comb.sv
// Combinational recursive Urdhva-Tiryagbhyam multiplier, N a power of two >= 2.
// N=2 is the bit-level base case; larger N splits into four N/2 products.
module vedic_nxn_comb
    import vedic_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    if (N == 2) begin : g_base
        logic t10_s;
        logic t01_s;
        logic t11_s;
        logic c1_s;

        assign t10_s = a[1] & b[0];
        assign t01_s = a[0] & b[1];
        assign t11_s = a[1] & b[1];
        assign c1_s  = t10_s & t01_s;
        assign p     = {t11_s & c1_s, t11_s ^ c1_s, t10_s ^ t01_s, a[0] & b[0]};
    end else begin : g_rec
        localparam int HN = half_w(N);

        logic [N-1:0] q0_s;
        logic [N-1:0] q1_s;
        logic [N-1:0] q2_s;
        logic [N-1:0] q3_s;
        logic [N:0]   mid_s;

        vedic_nxn_comb #(.N(HN)) u_q0 (.a(a[HN-1:0]), .b(b[HN-1:0]), .p(q0_s));
        vedic_nxn_comb #(.N(HN)) u_q1 (.a(a[N-1:HN]), .b(b[HN-1:0]), .p(q1_s));
        vedic_nxn_comb #(.N(HN)) u_q2 (.a(a[HN-1:0]), .b(b[N-1:HN]), .p(q2_s));
        vedic_nxn_comb #(.N(HN)) u_q3 (.a(a[N-1:HN]), .b(b[N-1:HN]), .p(q3_s));

        // Cross terms carry one extra bit before being placed at the half-width offset.
        assign mid_s = {1'b0, q1_s} + {1'b0, q2_s};
        assign p     = {q3_s, q0_s} + ({{(N-1){1'b0}}, mid_s} << HN);
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Two-stage pipelined Vedic multiplier with valid/ready on both sides and a sideband tag.
// Define VEDIC_SIGNED_EN to add in_signed for per-operation two's-complement operands.
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    localparam int H      = half_w(WIDTH),
    localparam int PROD_W = prod_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [TAG_W-1:0]  in_tag,
`ifdef VEDIC_SIGNED_EN
    input  logic              in_signed,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    typedef struct packed {
        logic [WIDTH-1:0] q0;
        logic [WIDTH-1:0] q1;
        logic [WIDTH-1:0] q2;
        logic [WIDTH-1:0] q3;
        logic [TAG_W-1:0] tag;
        logic             sign;
    } s1_payload_t;

    s1_payload_t       s1_r;
    s1_payload_t       s1_next_s;
    logic              s1_valid_r;
    logic              s2_valid_r;
    logic              s1_en_s;
    logic              s2_en_s;
    logic              accept_s;
    logic [WIDTH-1:0]  a_mag_s;
    logic [WIDTH-1:0]  b_mag_s;
    logic              sign_s;
    logic [WIDTH-1:0]  q0_s;
    logic [WIDTH-1:0]  q1_s;
    logic [WIDTH-1:0]  q2_s;
    logic [WIDTH-1:0]  q3_s;
    logic [WIDTH:0]    mid_s;
    logic [PROD_W-1:0] sum_s;
    logic [PROD_W-1:0] prod_s;

    assign s2_en_s  = ~s2_valid_r | out_ready;
    assign s1_en_s  = ~s1_valid_r | s2_en_s;
    assign in_ready = s1_en_s;
    assign accept_s = in_valid & s1_en_s;

    // Operand magnitudes and product sign; |-2^(W-1)| still fits unsigned in WIDTH bits.
    always_comb begin
        a_mag_s = in_a;
        b_mag_s = in_b;
        sign_s  = 1'b0;
`ifdef VEDIC_SIGNED_EN
        if (in_signed) begin
            a_mag_s = in_a[WIDTH-1] ? (~in_a + WIDTH'(1'b1)) : in_a;
            b_mag_s = in_b[WIDTH-1] ? (~in_b + WIDTH'(1'b1)) : in_b;
            sign_s  = in_a[WIDTH-1] ^ in_b[WIDTH-1];
        end else begin
            sign_s  = 1'b0;
        end
`endif
    end

    vedic_nxn_comb #(.N(H)) u_q0 (.a(a_mag_s[H-1:0]),     .b(b_mag_s[H-1:0]),     .p(q0_s));
    vedic_nxn_comb #(.N(H)) u_q1 (.a(a_mag_s[WIDTH-1:H]), .b(b_mag_s[H-1:0]),     .p(q1_s));
    vedic_nxn_comb #(.N(H)) u_q2 (.a(a_mag_s[H-1:0]),     .b(b_mag_s[WIDTH-1:H]), .p(q2_s));
    vedic_nxn_comb #(.N(H)) u_q3 (.a(a_mag_s[WIDTH-1:H]), .b(b_mag_s[WIDTH-1:H]), .p(q3_s));

    // Pack the stage-1 payload from the partial products and sideband.
    always_comb begin
        s1_next_s      = '0;
        s1_next_s.q0   = q0_s;
        s1_next_s.q1   = q1_s;
        s1_next_s.q2   = q2_s;
        s1_next_s.q3   = q3_s;
        s1_next_s.tag  = in_tag;
        s1_next_s.sign = sign_s;
    end

    // Stage-2 recombination of the registered partial products, then sign restore.
    always_comb begin
        mid_s  = {1'b0, s1_r.q1} + {1'b0, s1_r.q2};
        sum_s  = {s1_r.q3, s1_r.q0} + ({{(WIDTH-1){1'b0}}, mid_s} << H);
        prod_s = s1_r.sign ? (~sum_s + PROD_W'(1'b1)) : sum_s;
    end

    // Stage 1: load on accept, empty when drained without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_r       <= s1_next_s;
        end else if (s1_en_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2 doubles as the output register; it holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            out_prod   <= '0;
            out_tag    <= '0;
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            out_prod   <= prod_s;
            out_tag    <= s1_r.tag;
        end
    end

    assign out_valid = s2_valid_r;
    assign busy      = s1_valid_r | s2_valid_r;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench: 8-bit and 16-bit instances against an arithmetic reference model.
module tb_vedic_mult_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        i8_valid, i8_ready, o8_valid, o8_ready, busy8;
    logic [7:0]  i8_a, i8_b;
    logic [3:0]  i8_tag, o8_tag;
    logic [15:0] o8_prod;
    logic        i16_valid, i16_ready, o16_valid, o16_ready, busy16;
    logic [15:0] i16_a, i16_b;
    logic [3:0]  i16_tag, o16_tag;
    logic [31:0] o16_prod;
`ifdef VEDIC_SIGNED_EN
    logic        i8_sgn, i16_sgn;
`endif

    vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(i8_valid), .in_ready(i8_ready),
        .in_a(i8_a), .in_b(i8_b), .in_tag(i8_tag),
`ifdef VEDIC_SIGNED_EN
        .in_signed(i8_sgn),
`endif
        .out_valid(o8_valid), .out_ready(o8_ready), .out_prod(o8_prod),
        .out_tag(o8_tag), .busy(busy8));

    vedic_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(i16_valid), .in_ready(i16_ready),
        .in_a(i16_a), .in_b(i16_b), .in_tag(i16_tag),
`ifdef VEDIC_SIGNED_EN
        .in_signed(i16_sgn),
`endif
        .out_valid(o16_valid), .out_ready(o16_ready), .out_prod(o16_prod),
        .out_tag(o16_tag), .busy(busy16));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] q8p[$];
    logic [3:0]  q8t[$];
    logic [31:0] q16p[$];
    logic [3:0]  q16t[$];

    // Per-cycle observations, filled by tick()
    logic        f8, acc8, have8, f16, acc16, have16;
    logic [15:0] got8_p, exp8_p;
    logic [3:0]  got8_t, exp8_t, got16_t, exp16_t;
    logic [31:0] got16_p, exp16_p;

    // Reference: exact integer product, reduced modulo 2^(2w)
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic sg);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (sg && a[w-1]) sa = sa - (longint'(1) << w);
        if (sg && b[w-1]) sb = sb - (longint'(1) << w);
        p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    task automatic tick();
        logic        sg8, sg16;
        logic [31:0] r;
        @(negedge clk);
        sg8  = 1'b0;
        sg16 = 1'b0;
`ifdef VEDIC_SIGNED_EN
        sg8  = i8_sgn;
        sg16 = i16_sgn;
`endif
        f8    = o8_valid && o8_ready;
        acc8  = i8_valid && i8_ready;
        f16   = o16_valid && o16_ready;
        acc16 = i16_valid && i16_ready;
        have8 = 1'b0;
        have16 = 1'b0;
        if (f8) begin
            got8_p = o8_prod; got8_t = o8_tag; have8 = (q8p.size() != 0);
            if (have8) begin exp8_p = q8p.pop_front(); exp8_t = q8t.pop_front(); end
        end
        if (f16) begin
            got16_p = o16_prod; got16_t = o16_tag; have16 = (q16p.size() != 0);
            if (have16) begin exp16_p = q16p.pop_front(); exp16_t = q16t.pop_front(); end
        end
        if (acc8) begin
            r = ref_mul(8, {8'h00, i8_a}, {8'h00, i8_b}, sg8);
            q8p.push_back(r[15:0]);
            q8t.push_back(i8_tag);
        end
        if (acc16) begin
            r = ref_mul(16, i16_a, i16_b, sg16);
            q16p.push_back(r);
            q16t.push_back(i16_tag);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (o8_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", o8_valid); end
        checks++; if (o8_prod !== 16'h0000) begin errors++; $display("FAIL rst_out_prod got=%h exp=0000", o8_prod); end
        checks++; if (o8_tag !== 4'h0) begin errors++; $display("FAIL rst_out_tag got=%h exp=0", o8_tag); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy8); end
        checks++; if (o16_prod !== 32'h0 || o16_valid !== 1'b0) begin
            errors++; $display("FAIL rst_dut16 got=%b/%h exp=0/00000000", o16_valid, o16_prod); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (i8_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", i8_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_corners();
        logic [7:0]  ta [3] = '{8'h00, 8'hFF, 8'h0F};
        logic [7:0]  tb [3] = '{8'hAB, 8'hFF, 8'hF0};
        logic [15:0] tp [3] = '{16'h0000, 16'hFE01, 16'h0E10};
        o8_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i8_valid = 1'b1; i8_a = ta[k]; i8_b = tb[k]; i8_tag = 4'(k + 9);
            tick();
            checks++; if (!acc8) begin errors++; $display("FAIL corner_accept got=0 exp=1 k=%0d", k); end
            i8_valid = 1'b0;
            tick();
            checks++; if (f8) begin errors++; $display("FAIL corner_early got=1 exp=0 k=%0d", k); end
            tick();
            checks++;
            if (!f8 || got8_p !== tp[k] || got8_t !== 4'(k + 9)) begin
                errors++; $display("FAIL corner_prod got=%b/%h/%h exp=1/%h/%h", f8, got8_p, got8_t, tp[k], 4'(k + 9));
            end
        end
    endtask

    task automatic test_back_to_back();
        int first = -1, last = -1, n = 0;
        o8_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i < 16) begin
                i8_valid = 1'b1; i8_a = 8'($urandom); i8_b = 8'($urandom); i8_tag = i[3:0];
            end else begin
                i8_valid = 1'b0;
            end
            tick();
            if (i < 16) begin
                checks++; if (!acc8) begin errors++; $display("FAIL b2b_in_ready got=0 exp=1 i=%0d", i); end
            end
            if (f8) begin
                checks++;
                if (!have8 || got8_p !== exp8_p || got8_t !== 4'(n)) begin
                    errors++; $display("FAIL b2b_data got=%h/%h exp=%h/%h", got8_p, got8_t, exp8_p, 4'(n));
                end
                if (first < 0) first = cyc;
                last = cyc;
                n++;
            end
        end
        checks++;
        if (n != 16 || last - first != 15) begin
            errors++; $display("FAIL b2b_stream got=%0d results over %0d cycles exp=16 over 16", n, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        o8_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i8_valid = 1'b1; i8_a = 8'($urandom); i8_b = 8'($urandom); i8_tag = 4'(k + 1);
            tick();
            checks++; if (!acc8) begin errors++; $display("FAIL bp_fill got=0 exp=1 k=%0d", k); end
        end
        i8_a = 8'($urandom); i8_b = 8'($urandom); i8_tag = 4'h3;
        held = q8p[0];
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (acc8 || o8_valid !== 1'b1 || o8_prod !== held || busy8 !== 1'b1) begin
                errors++; $display("FAIL bp_stall got=acc%b v%b %h exp=acc0 v1 %h", acc8, o8_valid, o8_prod, held);
            end
        end
        o8_ready = 1'b1;
        tick();
        checks++;
        if (!f8 || !acc8 || !have8 || got8_p !== exp8_p || got8_t !== 4'h1) begin
            errors++; $display("FAIL bp_release got=f%b a%b %h/%h exp=f1 a1 %h/1", f8, acc8, got8_p, got8_t, exp8_p);
        end
        i8_valid = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            tick();
            checks++;
            if (!f8 || !have8 || got8_p !== exp8_p || got8_t !== 4'(k)) begin
                errors++; $display("FAIL bp_drain got=f%b %h/%h exp=f1 %h/%h", f8, got8_p, got8_t, exp8_p, 4'(k));
            end
        end
        tick();
        checks++; if (busy8 !== 1'b0 || q8p.size() != 0) begin
            errors++; $display("FAIL bp_empty got=busy%b q%0d exp=busy0 q0", busy8, q8p.size()); end
    endtask

    task automatic test_reset_mid();
        o8_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i8_valid = 1'b1; i8_a = 8'($urandom); i8_b = 8'($urandom); i8_tag = 4'(k);
            tick();
        end
        i8_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o8_valid !== 1'b0 || busy8 !== 1'b0) begin
            errors++; $display("FAIL mid_reset got=v%b busy%b exp=v0 busy0", o8_valid, busy8); end
        q8p.delete(); q8t.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (o8_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got=1 exp=0 k=%0d", k); end
        end
    endtask

    task automatic test_random16();
        int sent = 0, recv = 0, budget = 0;
        logic pending = 1'b0;
        i16_valid = 1'b0;
        while (recv < 1000 && budget < 20000) begin
            if (!pending) begin
                i16_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
                i16_a   = (sent == 0) ? 16'hFFFF : 16'($urandom);
                i16_b   = (sent == 0) ? 16'hFFFF : 16'($urandom);
                i16_tag = 4'(sent);
`ifdef VEDIC_SIGNED_EN
                i16_sgn = (sent == 0) ? 1'b0 : 1'($urandom);
`endif
            end
            o16_ready = ($urandom_range(0, 3) != 0);
            tick();
            budget++;
            if (acc16) sent++;
            pending = i16_valid && !acc16;
            if (f16) begin
                checks++;
                if (!have16 || got16_p !== exp16_p || got16_t !== exp16_t) begin
                    errors++; $display("FAIL rnd16 got=%h/%h exp=%h/%h", got16_p, got16_t, exp16_p, exp16_t);
                end
                if (recv == 0) begin
                    checks++; if (got16_p !== 32'hFFFE0001) begin
                        errors++; $display("FAIL max16 got=%h exp=fffe0001", got16_p); end
                end
                recv++;
            end
        end
        i16_valid = 1'b0;
        checks++; if (recv != 1000) begin errors++; $display("FAIL rnd16_count got=%0d exp=1000", recv); end
    endtask

`ifdef VEDIC_SIGNED_EN
    task automatic test_signed();
        logic [7:0]  ta [5] = '{8'h80, 8'hFF, 8'h7F, 8'h80, 8'hFF};
        logic [7:0]  tb [5] = '{8'h80, 8'h02, 8'h81, 8'h80, 8'h02};
        logic        ts [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        // 127 * -127 = -16129
        logic [15:0] tp [5] = '{16'h4000, 16'hFFFE, 16'hC0FF, 16'h4000, 16'h01FE};
        o8_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i8_valid = 1'b1; i8_a = ta[k]; i8_b = tb[k]; i8_sgn = ts[k]; i8_tag = 4'(k);
            tick();
            i8_valid = 1'b0;
            tick();
            tick();
            checks++;
            if (!f8 || got8_p !== tp[k] || got8_p !== exp8_p) begin
                errors++; $display("FAIL signed got=%b/%h exp=1/%h k=%0d", f8, got8_p, tp[k], k);
            end
        end
        i8_sgn = 1'b0;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i8_valid = 1'b0; i8_a = 8'h00; i8_b = 8'h00; i8_tag = 4'h0; o8_ready = 1'b1;
        i16_valid = 1'b0; i16_a = 16'h0000; i16_b = 16'h0000; i16_tag = 4'h0; o16_ready = 1'b1;
`ifdef VEDIC_SIGNED_EN
        i8_sgn = 1'b0; i16_sgn = 1'b0;
`endif
        test_reset();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random16();
`ifdef VEDIC_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
